stopwatch_upcounter: RTL and testbench
======================================

Name: stopwatch_upcounter

Overview:
- Count-up MM:SS stopwatch, the counting-direction complement of the countdown egg-timer path.
- Counts elapsed seconds from 00:00 in BCD and supports start/stop, lap-freeze and clear.
- Saturates at 59:59 and flags it.
- Digit outputs drive the same four-digit display path as the countdown timer.

Parameters:
- TICKS_PER_SEC, 100_000_000: CLK100MHZ cycles per counted second; the bench uses a small value.

Ports:
- CLK100MHZ  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- startstop  in  1  button level; each rising edge toggles run/pause
- lap  in  1  button level; each rising edge toggles display freeze
- clear  in  1  button level; rising edge returns to 00:00 idle
- m10  out  4  BCD minutes tens, 0-5
- m1  out  4  BCD minutes units, 0-9
- s10  out  4  BCD seconds tens, 0-5
- s1  out  4  BCD seconds units, 0-9
- running  out  1  high while in RUN
- lap_active  out  1  high while display is frozen
- full  out  1  high while saturated at 59:59

Behaviour:
- Reset (rst=1, async): state IDLE, internal count 00:00, lap latch 00:00, prescaler 0, all outputs 0.
- Input conditioning:
  - Each button passes through a 2-flop synchronizer and a rising-edge detector, producing a one-cycle pulse.
  - A button held high produces exactly one pulse.
  - A pulse is valid 3 cycles after the input rises; its effect is registered on the next edge, giving 4-cycle latency to outputs.
- FSM states: IDLE, RUN, PAUSE, FULL.
  - IDLE, startstop pulse -> RUN.
  - RUN, startstop pulse -> PAUSE.
  - PAUSE, startstop pulse -> RUN.
  - RUN, tick while count==59:59 -> FULL.
  - FULL: startstop pulse is ignored.
  - Any state, clear pulse -> IDLE. Count, prescaler, lap latch and lap_active all zeroed.
- Same-cycle priority: clear > startstop > lap. Clear alone wins; lap and startstop in one cycle are both applied.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1 only in RUN.
  - Reset to 0 on every IDLE->RUN and PAUSE->RUN entry.
  - tick = prescaler at TICKS_PER_SEC-1 in RUN; the first increment lands exactly TICKS_PER_SEC cycles after RUN entry.
  - Frozen (not cleared) in PAUSE; restarted from 0 on resume, so any partial second is discarded.
- BCD increment on tick:
  - s1 wraps 9->0 and carries to s10.
  - s10 wraps 5->0 and carries to m1.
  - m1 wraps 9->0 and carries to m10.
  - No wrap past 59:59; the count holds there and the state goes to FULL. full=1 from the cycle after the saturating tick.
  - Digits are never outside their stated ranges.
- Lap:
  - Pulse when lap_active=0: latch the current count into the lap register and set lap_active=1.
  - Pulse when lap_active=1: set lap_active=0.
  - Lap is honoured in RUN, PAUSE and FULL; ignored in IDLE.
  - While frozen, counting continues internally.
- Outputs:
  - Digit outputs = lap register when lap_active=1, else live count. Registered.
  - running = (state==RUN).
  - full = (state==FULL).
- Reset asserted mid-count returns to the reset values immediately; no tick is produced until a new startstop pulse.

Decomposition:
- Shared package timer_pkg:
  - state enum (IDLE, RUN, PAUSE, FULL)
  - digit limits (DIG_MAX=9, TENS_MAX=5)
  - BCD digit type, 4 bits
  - The countdown path imports the same constants.
- Sub-module btn_edge_sync: 2-flop synchronizer plus rising-edge pulse. Ports CLK100MHZ, rst, din, pulse. Instantiated three times.
- The BCD chain stays inline.

Test Plan (TICKS_PER_SEC=4):
- Start count:
  - Stimulus: rst pulse, then startstop high 5 cycles, run 40 cycles.
  - Response: running=1 at cycle 4 after press; s1 increments every 4 cycles; after 10 ticks s10=1, s1=0.
- Pause and resume:
  - Stimulus: startstop mid-second with prescaler=2, wait 20 cycles, startstop again.
  - Response: digits constant while paused; next increment exactly 4 cycles after RUN re-entry.
- Carry chain and saturation:
  - Stimulus: run to 09:59, one more tick.
  - Response: 10:00.
  - Stimulus: continue to 59:59, one more tick.
  - Response: digits stay 5,9,5,9; full=1, running=0; further startstop ignored.
- Lap freeze:
  - Stimulus: lap at 00:03, wait 12 cycles, lap again.
  - Response: outputs hold 00:03 with lap_active=1; after release outputs show 00:06.
- Clear priority:
  - Stimulus: clear and startstop rising in the same cycle while in RUN at 00:07.
  - Response: IDLE, 00:00, running=0, lap_active=0; no restart.
- Async reset mid-run:
  - Stimulus: rst asserted between clock edges at 02:15.
  - Response: all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Types and constants shared by the MM:SS timer paths (count-up stopwatch and
// countdown egg timer): the control state encoding, BCD digit limits and the
// packed four-digit display word.
// -----------------------------------------------------------------------------
package timer_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_FULL  = 2'd3
  } state_e;

  localparam bcd_t DIG_MAX  = 4'd9;
  localparam bcd_t TENS_MAX = 4'd5;

  typedef struct packed {
    bcd_t m10;
    bcd_t m1;
    bcd_t s10;
    bcd_t s1;
  } mmss_t;

  localparam mmss_t MMSS_ZERO = mmss_t'(16'h0000);

  // True when every digit sits at its upper limit (59:59).
  function automatic logic mmss_at_max(input mmss_t t);
    return (t.m10 == TENS_MAX) && (t.m1 == DIG_MAX) &&
           (t.s10 == TENS_MAX) && (t.s1 == DIG_MAX);
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// -----------------------------------------------------------------------------
// btn_edge_sync
// Brings an asynchronous button level into the CLK100MHZ domain through two
// flops and emits a registered one-cycle pulse on each rising edge. A button
// held high yields exactly one pulse; the pulse is valid three cycles after
// the input rises.
//   CLK100MHZ  in   system clock
//   rst        in   asynchronous active-high reset
//   din        in   raw button level
//   pulse      out  one-cycle rising-edge pulse
// -----------------------------------------------------------------------------
module btn_edge_sync (
  input  logic CLK100MHZ,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  // [0],[1] form the synchronizer; [2] is the previous synchronized level.
  logic [2:0] sync_q;
  logic       pulse_q;

  // Synchronizer shift register and registered edge pulse.
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      sync_q  <= 3'b000;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], din};
      pulse_q <= sync_q[1] & ~sync_q[2];
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/stopwatch_upcounter.sv
// -----------------------------------------------------------------------------
// stopwatch_upcounter
// Count-up MM:SS stopwatch in BCD with start/stop, lap freeze and clear.
// Saturates at 59:59 and reports it on full.
//   CLK100MHZ        in   system clock, rising edge
//   rst              in   asynchronous active-high reset
//   startstop        in   button level, rising edge toggles run/pause
//   lap              in   button level, rising edge toggles display freeze
//   clear            in   button level, rising edge returns to 00:00 idle
//   m10/m1/s10/s1    out  BCD display digits (registered)
//   running          out  high while counting
//   lap_active       out  high while the display is frozen
//   full             out  high while saturated at 59:59
// -----------------------------------------------------------------------------
module stopwatch_upcounter
  import timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic       CLK100MHZ,
  input  logic       rst,
  input  logic       startstop,
  input  logic       lap,
  input  logic       clear,
  output logic [3:0] m10,
  output logic [3:0] m1,
  output logic [3:0] s10,
  output logic [3:0] s1,
  output logic       running,
  output logic       lap_active,
  output logic       full
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};

  logic ss_p_s, lap_p_s, clr_p_s;

  btn_edge_sync u_ss  (.CLK100MHZ(CLK100MHZ), .rst(rst), .din(startstop), .pulse(ss_p_s));
  btn_edge_sync u_lap (.CLK100MHZ(CLK100MHZ), .rst(rst), .din(lap),       .pulse(lap_p_s));
  btn_edge_sync u_clr (.CLK100MHZ(CLK100MHZ), .rst(rst), .din(clear),     .pulse(clr_p_s));

  state_e        state_q, state_d;
  mmss_t         count_q, count_d;
  mmss_t         lap_q, lap_d;
  logic          lap_act_q, lap_act_d;
  logic [PW-1:0] presc_q, presc_d;
  mmss_t         disp_q;
  logic          running_q, full_q;
  mmss_t         inc_s;
  logic          tick_s;
  logic          at_max_s;

  // Ripple BCD increment of the live count; each digit wraps at its own limit.
  always_comb begin
    inc_s = count_q;
    if (count_q.s1 == DIG_MAX) begin
      inc_s.s1 = 4'd0;
      if (count_q.s10 == TENS_MAX) begin
        inc_s.s10 = 4'd0;
        if (count_q.m1 == DIG_MAX) begin
          inc_s.m1 = 4'd0;
          if (count_q.m10 == TENS_MAX) begin
            inc_s.m10 = TENS_MAX;
          end else begin
            inc_s.m10 = count_q.m10 + 4'd1;
          end
        end else begin
          inc_s.m1 = count_q.m1 + 4'd1;
        end
      end else begin
        inc_s.s10 = count_q.s10 + 4'd1;
      end
    end else begin
      inc_s.s1 = count_q.s1 + 4'd1;
    end
  end

  // Control FSM, prescaler, count and lap latch next-state.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    lap_d     = lap_q;
    lap_act_d = lap_act_q;
    presc_d   = presc_q;
    at_max_s  = mmss_at_max(count_q);
    tick_s    = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

    if (clr_p_s) begin
      // Clear outranks everything else arriving in the same cycle.
      state_d   = ST_IDLE;
      count_d   = MMSS_ZERO;
      lap_d     = MMSS_ZERO;
      lap_act_d = 1'b0;
      presc_d   = PRESC_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          presc_d = PRESC_ZERO;
          if (ss_p_s) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (tick_s) begin
            presc_d = PRESC_ZERO;
            if (at_max_s) begin
              count_d = count_q;
            end else begin
              count_d = inc_s;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
          // Saturation wins over a pause request landing on the same tick.
          if (tick_s && at_max_s) begin
            state_d = ST_FULL;
          end else if (ss_p_s) begin
            state_d = ST_PAUSE;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (ss_p_s) begin
            // Partial second is discarded on resume.
            state_d = ST_RUN;
            presc_d = PRESC_ZERO;
          end else begin
            state_d = ST_PAUSE;
            presc_d = presc_q;
          end
        end
        ST_FULL: begin
          state_d = ST_FULL;
          presc_d = presc_q;
        end
        default: begin
          state_d = ST_IDLE;
          presc_d = PRESC_ZERO;
        end
      endcase

      // Lap toggles the freeze; it latches the pre-tick count of this cycle.
      if (lap_p_s && (state_q != ST_IDLE)) begin
        if (lap_act_q) begin
          lap_act_d = 1'b0;
          lap_d     = lap_q;
        end else begin
          lap_act_d = 1'b1;
          lap_d     = count_q;
        end
      end else begin
        lap_act_d = lap_act_q;
        lap_d     = lap_q;
      end
    end
  end

  // State, prescaler, count and lap registers.
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= MMSS_ZERO;
      lap_q     <= MMSS_ZERO;
      lap_act_q <= 1'b0;
      presc_q   <= PRESC_ZERO;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      lap_q     <= lap_d;
      lap_act_q <= lap_act_d;
      presc_q   <= presc_d;
    end
  end

  // Output registers are loaded from next-state so they change on the same
  // edge as the state they describe.
  always_ff @(posedge CLK100MHZ or posedge rst) begin
    if (rst) begin
      disp_q    <= MMSS_ZERO;
      running_q <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      disp_q    <= lap_act_d ? lap_d : count_d;
      running_q <= (state_d == ST_RUN);
      full_q    <= (state_d == ST_FULL);
    end
  end

  assign m10        = disp_q.m10;
  assign m1         = disp_q.m1;
  assign s10        = disp_q.s10;
  assign s1         = disp_q.s1;
  assign running    = running_q;
  assign lap_active = lap_act_q;
  assign full       = full_q;

endmodule

// File: tb/tb_stopwatch_upcounter.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_upcounter
// Directed bench for the count-up stopwatch with TICKS_PER_SEC = 4.
// Observed word = {m10,m1,s10,s1, running, lap_active, full}.
// -----------------------------------------------------------------------------
module tb_stopwatch_upcounter;

  logic       clk;
  logic       rst;
  logic       startstop;
  logic       lap;
  logic       clear;
  logic [3:0] m10, m1, s10, s1;
  logic       running, lap_active, full;

  int n_cmp;
  int n_bad;

  stopwatch_upcounter #(.TICKS_PER_SEC(4)) dut (
    .CLK100MHZ (clk),
    .rst       (rst),
    .startstop (startstop),
    .lap       (lap),
    .clear     (clear),
    .m10       (m10),
    .m1        (m1),
    .s10       (s10),
    .s1        (s1),
    .running   (running),
    .lap_active(lap_active),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ss;
    logic        lp;
    logic        cl;
    int          cyc;
    logic [18:0] exp;
  } vec_t;

  vec_t vt[14];

  function automatic logic [18:0] obs();
    return {m10, m1, s10, s1, running, lap_active, full};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    startstop = 1'b0;
    lap = 1'b0;
    clear = 1'b0;

    // Start from reset, press startstop for 5 cycles, then lap twice.
    // Cycle counts are edges since the previous row; RUN entry is 4 edges
    // after the press, then one second per 4 edges.
    vt[0]  = '{1'b1, 1'b0, 1'b0, 3,  {16'h0000, 3'b000}};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1,  {16'h0000, 3'b100}};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 1,  {16'h0000, 3'b100}};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 2,  {16'h0000, 3'b100}};
    vt[4]  = '{1'b0, 1'b0, 1'b0, 1,  {16'h0001, 3'b100}};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 4,  {16'h0002, 3'b100}};
    vt[6]  = '{1'b0, 1'b0, 1'b0, 28, {16'h0009, 3'b100}};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 3,  {16'h0009, 3'b100}};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 1,  {16'h0010, 3'b100}};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 3,  {16'h0010, 3'b100}};
    vt[10] = '{1'b0, 1'b1, 1'b0, 1,  {16'h0010, 3'b110}};
    vt[11] = '{1'b0, 1'b0, 1'b0, 8,  {16'h0010, 3'b110}};
    vt[12] = '{1'b0, 1'b1, 1'b0, 4,  {16'h0014, 3'b100}};
    vt[13] = '{1'b0, 1'b0, 1'b0, 1,  {16'h0014, 3'b100}};

    step(2);
    check("reset_state", obs(), 19'h00000);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      startstop = vt[i].ss;
      lap       = vt[i].lp;
      clear     = vt[i].cl;
      step(vt[i].cyc);
      check($sformatf("vec%0d", i), obs(), vt[i].exp);
    end
    lap = 1'b0;

    // Pause at 00:15, hold, then resume; first tick 4 edges after RUN entry.
    startstop = 1'b1;
    step(4);
    check("pause_entry", obs(), {16'h0015, 3'b000});
    step(1);
    startstop = 1'b0;
    step(15);
    check("pause_hold", obs(), {16'h0015, 3'b000});
    startstop = 1'b1;
    step(3);
    check("resume_pre", obs(), {16'h0015, 3'b000});
    step(1);
    check("resume_run", obs(), {16'h0015, 3'b100});
    step(1);
    startstop = 1'b0;
    step(2);
    check("resume_no_early_tick", obs(), {16'h0015, 3'b100});
    step(1);
    check("resume_first_tick", obs(), {16'h0016, 3'b100});

    // Carry into minutes and saturation at 59:59.
    step(4 * 583);
    check("at_0959", obs(), {16'h0959, 3'b100});
    step(4);
    check("carry_1000", obs(), {16'h1000, 3'b100});
    step(4 * 2999);
    check("at_5959", obs(), {16'h5959, 3'b100});
    step(4);
    check("saturate", obs(), {16'h5959, 3'b001});
    step(3);
    check("sat_hold", obs(), {16'h5959, 3'b001});
    startstop = 1'b1;
    step(6);
    check("full_ignores_ss", obs(), {16'h5959, 3'b001});
    startstop = 1'b0;
    lap = 1'b1;
    step(4);
    check("lap_in_full", obs(), {16'h5959, 3'b011});
    lap = 1'b0;
    step(2);
    lap = 1'b1;
    step(4);
    check("lap_release_full", obs(), {16'h5959, 3'b001});
    lap = 1'b0;

    // Clear from FULL back to idle.
    clear = 1'b1;
    step(4);
    check("clear_from_full", obs(), 19'h00000);
    step(1);
    clear = 1'b0;
    step(3);

    // Clear and startstop together at 00:07 in RUN: clear wins, no restart.
    startstop = 1'b1;
    step(5);
    startstop = 1'b0;
    step(24);
    clear = 1'b1;
    startstop = 1'b1;
    step(3);
    check("clr_pre", obs(), {16'h0007, 3'b100});
    step(1);
    check("clr_priority", obs(), 19'h00000);
    step(1);
    clear = 1'b0;
    startstop = 1'b0;
    step(20);
    check("clr_no_restart", obs(), 19'h00000);

    // Asynchronous reset between edges at 02:15.
    startstop = 1'b1;
    step(5);
    startstop = 1'b0;
    step(539);
    check("at_0215", obs(), {16'h0215, 3'b100});
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", obs(), 19'h00000);
    step(2);
    rst = 1'b0;
    step(12);
    check("post_reset_idle", obs(), 19'h00000);

    // Lap is ignored while idle.
    lap = 1'b1;
    step(6);
    check("lap_idle_ignored", obs(), 19'h00000);
    lap = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
